// File: rtl/udma_hyper_pkg.sv
`default_nettype none
// ============================================================================
// Package     : udma_hyper_pkg
// Description : Shared types for the HyperBus multi-channel burst scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package udma_hyper_pkg;

  // Context byte counters are held at the widest supported transfer size;
  // narrower TRANS_SIZE values are zero-extended into it.
  localparam int CTX_SIZE_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic                  active;
    logic                  rwn;
    logic [31:0]           addr;
    logic [CTX_SIZE_W-1:0] remaining;
  } ch_ctx_t;

  // Size of the next burst: whatever is left, capped at the burst limit.
  function automatic logic [CTX_SIZE_W-1:0] burst_len(
    input logic [CTX_SIZE_W-1:0] remaining,
    input logic [CTX_SIZE_W-1:0] max_burst
  );
    return (remaining > max_burst) ? max_burst : remaining;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udma_hyper_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : udma_hyper_rr_arb
// Description : Combinational round-robin pick. Returns the lowest-index
//               requester at or after last_ch+1, wrapping modulo NB_CH.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_hyper_rr_arb #(
  parameter int NB_CH = 8,
  parameter int CH_W  = 3
) (
  input  logic [NB_CH-1:0] req,
  input  logic [CH_W-1:0]  last_ch,
  output logic [CH_W-1:0]  idx,
  output logic             valid
);

  // Scan from the farthest offset down so the nearest requester after
  // last_ch is the one left standing.
  always_comb begin
    int cand;
    cand  = 0;
    idx   = '0;
    valid = 1'b0;
    for (int k = NB_CH; k >= 1; k--) begin
      cand = (int'(last_ch) + k) % NB_CH;
      if (req[cand]) begin
        idx   = CH_W'(cand);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/udma_hyper_ch_sched.sv
`default_nettype none
// ============================================================================
// Module      : udma_hyper_ch_sched
// Description : Multi-channel HyperBus transaction scheduler. Splits each
//               channel descriptor into bursts of at most MAX_BURST bytes and
//               round-robins bursts onto the single PHY transaction port.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_hyper_ch_sched
  import udma_hyper_pkg::*;
#(
  parameter  int NB_CH      = 8,
  parameter  int TRANS_SIZE = 16,
  parameter  int MAX_BURST  = 256,
  localparam int CH_W       = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                             sys_clk_i,
  input  logic                             rstn_i,
  input  logic                             clr_i,
  input  logic [NB_CH-1:0]                 ch_req_i,
  input  logic [NB_CH-1:0][31:0]           ch_addr_i,
  input  logic [NB_CH-1:0][TRANS_SIZE-1:0] ch_size_i,
  input  logic [NB_CH-1:0]                 ch_rwn_i,
  output logic [NB_CH-1:0]                 ch_gnt_o,
  output logic                             trans_valid_o,
  input  logic                             trans_ready_i,
  output logic [CH_W-1:0]                  trans_ch_o,
  output logic [31:0]                      trans_addr_o,
  output logic [TRANS_SIZE-1:0]            trans_size_o,
  output logic                             trans_rwn_o,
  input  logic                             trans_done_i,
  output logic [NB_CH-1:0]                 evt_eot_o,
  output logic                             busy_o
);

  localparam logic [CTX_SIZE_W-1:0] MAX_B = CTX_SIZE_W'(MAX_BURST);

  ch_ctx_t              ctx_q [NB_CH];
  sched_state_e         state_q;
  logic [NB_CH-1:0]     active;
  logic [NB_CH-1:0]     gnt;
  logic [NB_CH-1:0]     eot_q;
  logic [CH_W-1:0]      last_ch_q;
  logic [CH_W-1:0]      ch_q;
  logic [CH_W-1:0]      pick_idx;
  logic                 pick_valid;
  logic                 aborted_q;
  logic                 valid_q;
  logic                 rwn_q;
  logic [31:0]          addr_q;
  logic [TRANS_SIZE-1:0] size_q;
  logic                 done_upd;
  logic                 done_last;

  // Active vector for arbitration and same-cycle grant of idle contexts.
  always_comb begin
    active = '0;
    gnt    = '0;
    for (int i = 0; i < NB_CH; i++) begin
      active[i] = ctx_q[i].active;
      gnt[i]    = ch_req_i[i] && !ctx_q[i].active && !clr_i;
    end
  end

  // A completion only touches the context if the burst was not aborted.
  assign done_upd  = (state_q == WAIT_DONE) && trans_done_i && !aborted_q && !clr_i;
  assign done_last = (ctx_q[ch_q].remaining == CTX_SIZE_W'(size_q));

  udma_hyper_rr_arb #(
    .NB_CH (NB_CH),
    .CH_W  (CH_W)
  ) u_arb (
    .req     (active),
    .last_ch (last_ch_q),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  // Per-channel contexts: accept descriptors, advance on completions, raise eot.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NB_CH; i++) ctx_q[i] <= '0;
      eot_q <= '0;
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        eot_q[i] <= 1'b0;
        if (clr_i) begin
          ctx_q[i].active <= 1'b0;
        end else if (gnt[i]) begin
          ctx_q[i].active    <= (ch_size_i[i] != '0);
          ctx_q[i].rwn       <= ch_rwn_i[i];
          ctx_q[i].addr      <= ch_addr_i[i];
          ctx_q[i].remaining <= CTX_SIZE_W'(ch_size_i[i]);
          eot_q[i]           <= (ch_size_i[i] == '0);
        end else if (done_upd && (ch_q == CH_W'(i))) begin
          ctx_q[i].addr      <= ctx_q[i].addr + 32'(size_q);
          ctx_q[i].remaining <= ctx_q[i].remaining - CTX_SIZE_W'(size_q);
          if (done_last) begin
            ctx_q[i].active <= 1'b0;
            eot_q[i]        <= 1'b1;
          end
        end
      end
    end
  end

  // Burst FSM: arbitrate in IDLE, offer in ISSUE, await completion in WAIT_DONE.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      ch_q      <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      rwn_q     <= 1'b0;
      last_ch_q <= CH_W'(NB_CH - 1);
      aborted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!clr_i && pick_valid) begin
            ch_q    <= pick_idx;
            addr_q  <= ctx_q[pick_idx].addr;
            size_q  <= TRANS_SIZE'(burst_len(ctx_q[pick_idx].remaining, MAX_B));
            rwn_q   <= ctx_q[pick_idx].rwn;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (clr_i) aborted_q <= 1'b1;
          if (trans_ready_i) begin
            valid_q   <= 1'b0;
            last_ch_q <= ch_q;
            state_q   <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (trans_done_i) begin
            aborted_q <= 1'b0;
            state_q   <= IDLE;
          end else if (clr_i) begin
            aborted_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_gnt_o      = gnt;
  assign evt_eot_o     = eot_q;
  assign trans_valid_o = valid_q;
  assign trans_ch_o    = ch_q;
  assign trans_addr_o  = addr_q;
  assign trans_size_o  = size_q;
  assign trans_rwn_o   = rwn_q;
  assign busy_o        = (|active) || (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_udma_hyper_ch_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_udma_hyper_ch_sched
// Description : Self-checking bench for the HyperBus channel scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udma_hyper_ch_sched;

  localparam int NB_CH = 8;
  localparam int TS    = 16;
  localparam int MB    = 256;

  logic clk = 1'b0;
  logic rstn, clr, ready, done;
  logic [NB_CH-1:0]         req, rwn;
  logic [NB_CH-1:0][31:0]   addr;
  logic [NB_CH-1:0][TS-1:0] size;
  logic [NB_CH-1:0]         gnt, eot;
  logic                     valid, trwn, busy;
  logic [2:0]               tch;
  logic [31:0]              taddr;
  logic [TS-1:0]            tsize;

  // second instance with a 128-byte burst limit
  logic [NB_CH-1:0]         b_req, b_gnt, b_eot;
  logic [NB_CH-1:0][31:0]   b_addr;
  logic [NB_CH-1:0][TS-1:0] b_size;
  logic                     b_valid, b_done, b_rwn, b_busy;
  logic [2:0]               b_ch;
  logic [31:0]              b_taddr;
  logic [TS-1:0]            b_tsize;

  always #5 clk = ~clk;

  udma_hyper_ch_sched #(.NB_CH(NB_CH), .TRANS_SIZE(TS), .MAX_BURST(MB)) dut (
    .sys_clk_i(clk), .rstn_i(rstn), .clr_i(clr), .ch_req_i(req), .ch_addr_i(addr),
    .ch_size_i(size), .ch_rwn_i(rwn), .ch_gnt_o(gnt), .trans_valid_o(valid),
    .trans_ready_i(ready), .trans_ch_o(tch), .trans_addr_o(taddr), .trans_size_o(tsize),
    .trans_rwn_o(trwn), .trans_done_i(done), .evt_eot_o(eot), .busy_o(busy));

  udma_hyper_ch_sched #(.NB_CH(NB_CH), .TRANS_SIZE(TS), .MAX_BURST(128)) dut128 (
    .sys_clk_i(clk), .rstn_i(rstn), .clr_i(1'b0), .ch_req_i(b_req), .ch_addr_i(b_addr),
    .ch_size_i(b_size), .ch_rwn_i('0), .ch_gnt_o(b_gnt), .trans_valid_o(b_valid),
    .trans_ready_i(1'b1), .trans_ch_o(b_ch), .trans_addr_o(b_taddr), .trans_size_o(b_tsize),
    .trans_rwn_o(b_rwn), .trans_done_i(b_done), .evt_eot_o(b_eot), .busy_o(b_busy));

  int n_chk = 0, n_pass = 0, cyc = 0;

  // reference model: per-channel outstanding work plus the burst in flight
  bit          m_act [NB_CH];
  logic [31:0] m_addr[NB_CH];
  int unsigned m_rem [NB_CH];
  bit          m_rwn [NB_CH];
  int          m_last = NB_CH - 1;
  bit          m_offer = 0, m_wait = 0, m_abort = 0;
  int          m_cur_ch = 0, m_cur_size = 0, wait_cnt = 0;
  logic [31:0] m_cur_addr = '0;
  bit          m_cur_rwn = 0;
  logic [NB_CH-1:0] m_eot_next = '0;

  // bench control and observation
  bit rnd_mode = 0, ready_low = 0, done_auto = 1;
  bit saw_valid, saw_busy;
  int gnt_cyc, valid_cyc;
  logic [NB_CH-1:0] s_gnt;
  logic s_valid, s_busy;
  logic [2:0] s_ch;
  logic [31:0] s_addr;
  logic [TS-1:0] s_size;
  int log_ch[$], log_size[$], eot_log[$];
  logic [31:0] log_addr[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [NB_CH-1:0] m_act_vec();
    logic [NB_CH-1:0] v;
    for (int i = 0; i < NB_CH; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic bit model_idle();
    return (m_act_vec() == '0) && !m_offer && !m_wait && (m_eot_next == '0);
  endfunction

  task automatic clear_logs();
    log_ch.delete(); log_size.delete(); log_addr.delete(); eot_log.delete();
    saw_valid = 0; saw_busy = 0; gnt_cyc = -1; valid_cyc = -1;
  endtask

  // One clock: drive, compare against the model, advance the model.
  task automatic tick();
    logic [NB_CH-1:0] exp_gnt, n_eot;
    int c;
    if (rnd_mode) begin
      req = NB_CH'($urandom) & NB_CH'($urandom) & NB_CH'($urandom);
      for (int i = 0; i < NB_CH; i++) begin
        addr[i] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FE00 | 32'($urandom_range(0, 511))) : $urandom;
        size[i] = ($urandom_range(0, 7) == 0) ? '0 : TS'($urandom_range(1, 1200));
        rwn[i]  = 1'($urandom);
      end
      clr   = ($urandom_range(0, 99) == 0);
      ready = ($urandom_range(0, 3) != 0);
      done  = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
    end else begin
      ready = !ready_low;
      if (done_auto) done = m_wait && (wait_cnt >= 1);
    end
    #1;
    exp_gnt = clr ? '0 : (req & ~m_act_vec());
    chk("gnt", gnt, exp_gnt);
    chk("eot", eot, m_eot_next);
    chk("valid", valid, m_offer);
    chk("busy", busy, (m_act_vec() != '0) || m_offer || m_wait);
    if (m_offer) begin
      chk("burst_ch", tch, m_cur_ch);
      chk("burst_addr", taddr, m_cur_addr);
      chk("burst_size", tsize, m_cur_size);
      chk("burst_rwn", trwn, m_cur_rwn);
    end
    s_gnt = gnt; s_valid = valid; s_busy = busy; s_ch = tch; s_addr = taddr; s_size = tsize;
    if (valid && ready) begin
      log_ch.push_back(int'(tch)); log_addr.push_back(taddr); log_size.push_back(int'(tsize));
    end
    for (int i = 0; i < NB_CH; i++) if (eot[i]) eot_log.push_back(i);
    if (valid) saw_valid = 1;
    if (busy) saw_busy = 1;
    if (gnt != '0 && gnt_cyc < 0) gnt_cyc = cyc;
    if (valid && valid_cyc < 0) valid_cyc = cyc;

    @(posedge clk);
    n_eot = '0;
    if (m_offer) begin
      if (clr) m_abort = 1;
      if (ready) begin
        m_offer = 0; m_wait = 1; wait_cnt = 0; m_last = m_cur_ch;
      end
    end else if (m_wait) begin
      wait_cnt++;
      if (done) begin
        m_wait = 0;
        if (!m_abort && !clr) begin
          c = m_cur_ch;
          m_addr[c] = m_addr[c] + 32'(m_cur_size);
          m_rem[c]  = m_rem[c] - m_cur_size;
          if (m_rem[c] == 0) begin m_act[c] = 0; n_eot[c] = 1'b1; end
        end
        m_abort = 0;
      end else if (clr) m_abort = 1;
    end else if (!clr) begin
      for (int k = 1; k <= NB_CH; k++) begin
        c = (m_last + k) % NB_CH;
        if (m_act[c]) begin
          m_offer    = 1;
          m_cur_ch   = c;
          m_cur_addr = m_addr[c];
          m_cur_size = (m_rem[c] > MB) ? MB : int'(m_rem[c]);
          m_cur_rwn  = m_rwn[c];
          break;
        end
      end
    end
    if (clr) for (int i = 0; i < NB_CH; i++) m_act[i] = 0;
    for (int i = 0; i < NB_CH; i++) begin
      if (exp_gnt[i]) begin
        if (size[i] == '0) n_eot[i] = 1'b1;
        else begin
          m_act[i] = 1; m_addr[i] = addr[i]; m_rem[i] = size[i]; m_rwn[i] = rwn[i];
        end
      end
    end
    m_eot_next = n_eot;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && !model_idle(); n++) tick();
    chk("drain_done", model_idle(), 1);
    tick();
    chk("drain_busy", s_busy, 0);
  endtask

  typedef struct {
    int ch; logic [31:0] addr; int size; bit rwn;
    int nb; logic [31:0] fa; int fs; logic [31:0] la; int ls;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int exp_order[4];
    int pend, ecnt;
    logic [31:0] ba[$];
    int bs[$];

    tbl[0] = '{0, 32'h0000_1000,  600, 1, 3, 32'h0000_1000, 256, 32'h0000_1200,  88};
    tbl[1] = '{5, 32'hFFFF_FF80,  256, 0, 1, 32'hFFFF_FF80, 256, 32'hFFFF_FF80, 256};
    tbl[2] = '{7, 32'h0000_0020,    1, 1, 1, 32'h0000_0020,   1, 32'h0000_0020,   1};
    tbl[3] = '{4, 32'h0000_0100,  257, 1, 2, 32'h0000_0100, 256, 32'h0000_0200,   1};
    tbl[4] = '{6, 32'hFFFF_FF00,  512, 0, 2, 32'hFFFF_FF00, 256, 32'h0000_0000, 256};
    tbl[5] = '{2, 32'h0000_0000,    0, 1, 0, 32'h0, 0, 32'h0, 0};
    tbl[6] = '{3, 32'hABCD_0001, 1000, 0, 4, 32'hABCD_0001, 256, 32'hABCD_0301, 232};

    rstn = 0; clr = 0; ready = 1; done = 0; req = '0; addr = '0; size = '0; rwn = '0;
    b_req = '0; b_addr = '0; b_size = '0; b_done = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", valid, 0); chk("rst_ch", tch, 0); chk("rst_addr", taddr, 0);
    chk("rst_size", tsize, 0); chk("rst_rwn", trwn, 0); chk("rst_eot", eot, 0);
    chk("rst_busy", busy, 0); chk("rst_gnt", gnt, 0);
    @(negedge clk);
    rstn = 1;

    // channels 1 and 3 granted together: bursts alternate, eot[1] first
    clear_logs();
    req = 8'b0000_1010; size[1] = 512; size[3] = 512;
    addr[1] = 32'h2000; addr[3] = 32'h3000; rwn[1] = 1; rwn[3] = 0;
    tick();
    req = '0;
    drain();
    exp_order = '{1, 3, 1, 3};
    chk("rr_nbursts", log_ch.size(), 4);
    for (int k = 0; k < 4; k++) chk("rr_order", (k < log_ch.size()) ? log_ch[k] : -1, exp_order[k]);
    chk("rr_neot", eot_log.size(), 2);
    chk("rr_eot_first", (eot_log.size() > 0) ? eot_log[0] : -1, 1);
    chk("rr_eot_second", (eot_log.size() > 1) ? eot_log[1] : -1, 3);

    // table of single-channel transfers, PHY always ready
    foreach (tbl[t]) begin
      clear_logs();
      req[tbl[t].ch] = 1; addr[tbl[t].ch] = tbl[t].addr;
      size[tbl[t].ch] = TS'(tbl[t].size); rwn[tbl[t].ch] = tbl[t].rwn;
      tick();
      req = '0;
      drain();
      chk("tbl_nbursts", log_ch.size(), tbl[t].nb);
      chk("tbl_neot", eot_log.size(), 1);
      chk("tbl_eot_ch", (eot_log.size() > 0) ? eot_log[0] : -1, tbl[t].ch);
      if (tbl[t].nb == 0) begin
        chk("size0_no_valid", saw_valid, 0);
        chk("size0_no_busy", saw_busy, 0);
      end else if (log_addr.size() > 0) begin
        chk("tbl_first_ch", log_ch[0], tbl[t].ch);
        chk("tbl_first_addr", log_addr[0], tbl[t].fa);
        chk("tbl_first_size", log_size[0], tbl[t].fs);
        chk("tbl_last_addr", log_addr[log_addr.size()-1], tbl[t].la);
        chk("tbl_last_size", log_size[log_size.size()-1], tbl[t].ls);
        chk("tbl_latency", valid_cyc - gnt_cyc, 2);
      end
    end

    // PHY stalls 5 cycles: the offered burst holds steady
    clear_logs();
    ready_low = 1;
    req[4] = 1; addr[4] = 32'h4440; size[4] = 100; rwn[4] = 1;
    tick();
    req = '0;
    for (int n = 0; n < 10 && !m_offer; n++) tick();
    for (int s = 0; s < 6; s++) begin
      if (s == 5) ready_low = 0;
      tick();
      chk("stall_valid", s_valid, 1); chk("stall_ch", s_ch, 4);
      chk("stall_addr", s_addr, 32'h4440); chk("stall_size", s_size, 100);
    end
    drain();
    chk("stall_nbursts", log_ch.size(), 1);

    // abort while a burst is outstanding
    clear_logs();
    done_auto = 0; done = 0;
    req[0] = 1; addr[0] = 32'h8000; size[0] = 300; rwn[0] = 0;
    tick();
    req = '0;
    for (int n = 0; n < 10 && !m_wait; n++) tick();
    clr = 1; tick(); clr = 0;
    tick();
    done = 1; tick(); done = 0;
    done_auto = 1;
    req[0] = 1; addr[0] = 32'h9000; size[0] = 16;
    tick();
    req = '0;
    chk("clr_regrant", s_gnt[0], 1);
    chk("clr_busy", s_busy, 0);
    chk("clr_no_eot", eot_log.size(), 0);
    drain();
    chk("clr_nbursts", log_ch.size(), 2);
    chk("clr_second_addr", (log_addr.size() > 1) ? log_addr[1] : 32'hDEAD, 32'h9000);
    chk("clr_neot", eot_log.size(), 1);

    // 128-byte limit: the second burst wraps to address 0
    b_addr[0] = 32'hFFFF_FF80; b_size[0] = 256; b_req = 8'h01;
    pend = 0; ecnt = 0;
    for (int n = 0; n < 30; n++) begin
      b_done = (pend != 0);
      #1;
      pend = b_valid ? 1 : 0;
      if (b_valid) begin ba.push_back(b_taddr); bs.push_back(int'(b_tsize)); end
      if (b_eot[0]) ecnt++;
      @(negedge clk);
      b_req = '0;
    end
    b_done = 0;
    chk("w128_nbursts", ba.size(), 2);
    chk("w128_addr0", (ba.size() > 0) ? ba[0] : 32'hDEAD, 32'hFFFF_FF80);
    chk("w128_addr1", (ba.size() > 1) ? ba[1] : 32'hDEAD, 32'h0000_0000);
    chk("w128_size0", (bs.size() > 0) ? bs[0] : -1, 128);
    chk("w128_size1", (bs.size() > 1) ? bs[1] : -1, 128);
    chk("w128_eot", ecnt, 1);

    // randomized traffic against the reference model
    rnd_mode = 1;
    for (int n = 0; n < 3000; n++) tick();
    rnd_mode = 0; req = '0; clr = 0; ready_low = 0; done_auto = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udma_hyper_ch_sched.md
# udma_hyper_ch_sched

Multi-channel transaction scheduler in front of the HyperBus PHY controller. Accepts up to NB_CH independent transfer descriptors, splits each into bursts of at most MAX_BURST bytes, and round-robins bursts across channels so no channel monopolises the single PHY. Signals per-channel end-of-transfer. Sits between the per-channel register files and the PHY transaction port in the `sys_clk_i` domain.

## Interface
- NB_CH, 8, number of channels.
- TRANS_SIZE, 16, width of transfer byte count.
- MAX_BURST, 256, maximum bytes per issued burst; power of two, at most 2^(TRANS_SIZE-1).
- sys_clk_i  in  1  clock; single clock domain.
- rstn_i  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous abort of all channels.
- ch_req_i  in  NB_CH  per-channel descriptor valid.
- ch_addr_i  in  NB_CH x 32  external start byte address.
- ch_size_i  in  NB_CH x TRANS_SIZE  transfer size in bytes.
- ch_rwn_i  in  NB_CH  1 = read, 0 = write.
- ch_gnt_o  out  NB_CH  one-cycle descriptor accept pulse.
- trans_valid_o  out  1  burst request valid.
- trans_ready_i  in  1  PHY accepts burst.
- trans_ch_o  out  $clog2(NB_CH)  channel ID of burst.
- trans_addr_o  out  32  burst start byte address.
- trans_size_o  out  TRANS_SIZE  burst byte count, 1..MAX_BURST.
- trans_rwn_o  out  1  burst direction.
- trans_done_i  in  1  one-cycle pulse: accepted burst completed.
- evt_eot_o  out  NB_CH  one-cycle end-of-transfer pulse.
- busy_o  out  1  any context active or FSM not IDLE.

## Operation
- Per-channel context: active, rwn, addr[31:0], remaining[TRANS_SIZE-1:0].
- Accept: if `ch_req_i[i]` and context i inactive and `clr_i` low → latch descriptor, set active, pulse `ch_gnt_o[i]` the same cycle. All channels may be accepted in parallel. Requests on active channels stall (no gnt).
- Size 0: granted, context never goes active, `evt_eot_o[i]` pulses the next cycle, no burst issued.
- FSM IDLE → ISSUE → WAIT_DONE → IDLE.
- IDLE: if any context is active, pick the lowest-index active channel at or after last_ch+1 (mod NB_CH). Register chunk = min(remaining, MAX_BURST), then go to ISSUE. last_ch resets to NB_CH-1, so channel 0 has first priority.
- ISSUE: `trans_valid_o`=1 and outputs stable until `trans_ready_i`. On handshake go to WAIT_DONE and set last_ch = the issued channel.
- WAIT_DONE: on `trans_done_i`, addr += chunk and remaining -= chunk. If remaining becomes 0, clear active and pulse `evt_eot_o[ch]` the next cycle. Go to IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32. No boundary splitting other than MAX_BURST.
- clr_i:
  - Clears all contexts and suppresses grants that cycle.
  - In ISSUE, the burst is still offered until the handshake.
  - Any outstanding burst still completes through WAIT_DONE, but it does not update a context and does not produce an eot.
  - No eot pulses result from clr_i.
- `trans_done_i` outside WAIT_DONE is ignored.

## Timing
- Reset values: all outputs 0; contexts inactive; FSM IDLE; last_ch = NB_CH-1.
- Grant to first `trans_valid_o`: 2 cycles (IDLE arbitration, then ISSUE).
- Done to next `trans_valid_o`: 2 cycles. There is a mandatory IDLE arbitration cycle between bursts.
- `evt_eot_o` asserts 1 cycle after the final `trans_done_i`. The context becomes grantable again in that same cycle.
- Eot and a new grant on different channels may occur in the same cycle.
- Reset mid-burst aborts immediately. The PHY must be reset alongside.

## Structure
- `udma_hyper_pkg`: `sched_state_e` (IDLE, ISSUE, WAIT_DONE) and `ch_ctx_t` struct.
- Sub-module `udma_hyper_rr_arb`: combinational round-robin pick, with inputs req[NB_CH] and last_ch, and outputs idx and valid.
- Top-level holds the context array, FSM, and chunk/eot registers.

## Test plan
- Ch0 read, addr 0x1000, size 600, MAX_BURST 256, ready tied high → bursts (0x1000,256), (0x1100,256), (0x1200,88); one `evt_eot_o[0]` pulse after the 3rd done.
- Ch1 and ch3 both size 512, granted the same cycle → issue order ch1, ch3, ch1, ch3; eot[1] precedes eot[3].
- Size 0 on ch2 → gnt[2], eot[2] next cycle, `trans_valid_o` never rises, `busy_o` stays 0.
- `trans_ready_i` held low 5 cycles in ISSUE → `trans_valid_o`, addr, size and ch remain stable for all 6 cycles.
- `clr_i` during WAIT_DONE with ch0 remaining 300 → done accepted, no eot, FSM IDLE, `busy_o`=0; a new ch0 request is granted the cycle after.
- Addr 0xFFFF_FF80, size 256 → bursts at 0xFFFF_FF80 size 256, then eot; repeat with MAX_BURST 128 → second burst addr 0x0000_0000.
